// File: rtl/serial_quantizer_encoder.sv
// Serial quantizer encoder: emits {exponent, mantissa} from the leading-one location of a 32-bit word.
// Optional build macro ROUND_NEAREST_EN enables round-half-up in FIN; otherwise the mantissa is truncated.
module serial_quantizer_encoder #(
    parameter int unsigned MANT_BITS = 4,
    parameter int unsigned EXP_BITS  = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_word,
    output logic [31:0]                   lod_word,
    input  logic [EXP_BITS-1:0]           lod_location,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [EXP_BITS+MANT_BITS-1:0] out_code,
    output logic                          busy
);

    typedef enum logic [2:0] {IDLE, LOD1, LOD2, SHIFT, FIN, OUT} state_t;

    state_t                          state, state_next;
    logic [31:0]                     word_next;
    logic [EXP_BITS-1:0]             exp_q, exp_next;
    logic [MANT_BITS-1:0]            mant, mant_next;
    logic signed [6:0]               idx, idx_next;
    logic [3:0]                      cnt, cnt_next;
    logic [EXP_BITS+MANT_BITS-1:0]   code_next;
    logic                            valid_next;
    logic                            sel_bit;
`ifdef ROUND_NEAREST_EN
    logic [MANT_BITS:0]              rounded;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lod_word  <= '0;
            exp_q     <= '0;
            mant      <= '0;
            idx       <= '0;
            cnt       <= '0;
            out_code  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            lod_word  <= word_next;
            exp_q     <= exp_next;
            mant      <= mant_next;
            idx       <= idx_next;
            cnt       <= cnt_next;
            out_code  <= code_next;
            out_valid <= valid_next;
        end
    end

    always_comb begin
        state_next = state;
        word_next  = lod_word;
        exp_next   = exp_q;
        mant_next  = mant;
        idx_next   = idx;
        cnt_next   = cnt;
        code_next  = out_code;
        valid_next = out_valid;
        in_ready   = (state == IDLE);
        busy       = (state != IDLE);
        // Negative (or out-of-range) index reads as zero: bits below bit 0 are zero-filled.
        sel_bit    = (idx[6] || idx[5]) ? 1'b0 : lod_word[idx[4:0]];
`ifdef ROUND_NEAREST_EN
        rounded    = '0;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    word_next  = in_word;
                    state_next = LOD1;
                end
            end
            LOD1: state_next = LOD2;
            LOD2: begin
                exp_next = lod_location;
                if (lod_location == '0) begin
                    mant_next  = '0;
                    code_next  = '0;
                    valid_next = 1'b1;
                    state_next = OUT;
                end else begin
                    idx_next   = $signed({1'b0, lod_location}) - 7'sd2;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                mant_next = (mant << 1) | MANT_BITS'(sel_bit);
                idx_next  = idx - 7'sd1;
                cnt_next  = cnt + 4'd1;
                if (cnt == 4'(MANT_BITS - 1))
                    state_next = FIN;
            end
            FIN: begin
`ifdef ROUND_NEAREST_EN
                // idx now addresses the guard bit; a carry out bumps the exponent.
                rounded = {1'b0, mant} + (MANT_BITS + 1)'(sel_bit);
                if (rounded[MANT_BITS]) begin
                    if (exp_q == EXP_BITS'(32)) begin
                        mant_next = {MANT_BITS{1'b1}};
                        code_next = {exp_q, {MANT_BITS{1'b1}}};
                    end else begin
                        exp_next  = exp_q + EXP_BITS'(1);
                        mant_next = '0;
                        code_next = {exp_q + EXP_BITS'(1), {MANT_BITS{1'b0}}};
                    end
                end else begin
                    mant_next = rounded[MANT_BITS-1:0];
                    code_next = {exp_q, rounded[MANT_BITS-1:0]};
                end
`else
                code_next = {exp_q, mant};
`endif
                valid_next = 1'b1;
                state_next = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
